// File: rtl/id_ex_stage_reg_pkg.sv
// Shared encodings for the ID/EX pipeline register: control-field widths,
// packed control/index bundles and the all-zero bubble constants.
package id_ex_stage_reg_pkg;

   localparam int ALU_OP_W = 5;
   localparam int MEM_RD_W = 4;
   localparam int MEM_WR_W = 3;
   localparam int BJ_W     = 3;
   localparam int WB_W     = 2;
   localparam int REG_W    = 5;

   typedef struct packed {
      logic [ALU_OP_W-1:0] alu_op;
      logic                reg_write_en;
      logic                data1_alu_sel;
      logic                data2_alu_sel;
      logic [MEM_WR_W-1:0] mem_write;
      logic [MEM_RD_W-1:0] mem_read;
      logic [BJ_W-1:0]     branch_jump;
      logic [WB_W-1:0]     wb_sel;
   } ctrl_t;

   typedef struct packed {
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
   } regs_t;

   // A bubble is all-zero: no register write, no memory access, no branch.
   localparam ctrl_t CTRL_NOP = '0;
   localparam regs_t REGS_NOP = '0;

   function automatic logic is_load(input logic [MEM_RD_W-1:0] mem_read);
      return |mem_read;
   endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX bundle: decoded ID-side inputs, pipeline control, and the registered
// EX-side copies plus stall/perf outputs.
interface id_ex_stage_reg_if #(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 32
);
   import id_ex_stage_reg_pkg::*;

   logic                id_valid;
   logic [XLEN-1:0]     id_pc;
   logic [XLEN-1:0]     id_data1;
   logic [XLEN-1:0]     id_data2;
   logic [XLEN-1:0]     id_imm;
   logic [REG_W-1:0]    id_rs1;
   logic [REG_W-1:0]    id_rs2;
   logic [REG_W-1:0]    id_rd;
   logic                id_rs1_used;
   logic                id_rs2_used;
   logic [ALU_OP_W-1:0] id_alu_op;
   logic                id_reg_write_en;
   logic                id_data1_alu_sel;
   logic                id_data2_alu_sel;
   logic [MEM_WR_W-1:0] id_mem_write;
   logic [MEM_RD_W-1:0] id_mem_read;
   logic [BJ_W-1:0]     id_branch_jump;
   logic [WB_W-1:0]     id_wb_sel;
   logic                flush;
   logic                ex_stall;

   logic                 ex_valid;
   logic [XLEN-1:0]      ex_pc;
   logic [XLEN-1:0]      ex_data1;
   logic [XLEN-1:0]      ex_data2;
   logic [XLEN-1:0]      ex_imm;
   logic [REG_W-1:0]     ex_rs1;
   logic [REG_W-1:0]     ex_rs2;
   logic [REG_W-1:0]     ex_rd;
   logic [ALU_OP_W-1:0]  ex_alu_op;
   logic                 ex_reg_write_en;
   logic                 ex_data1_alu_sel;
   logic                 ex_data2_alu_sel;
   logic [MEM_WR_W-1:0]  ex_mem_write;
   logic [MEM_RD_W-1:0]  ex_mem_read;
   logic [BJ_W-1:0]      ex_branch_jump;
   logic [WB_W-1:0]      ex_wb_sel;
   logic                 stall_out;
   logic [CNT_WIDTH-1:0] bubble_cnt;

   modport master (
      output id_valid, id_pc, id_data1, id_data2, id_imm, id_rs1, id_rs2, id_rd,
             id_rs1_used, id_rs2_used, id_alu_op, id_reg_write_en,
             id_data1_alu_sel, id_data2_alu_sel, id_mem_write, id_mem_read,
             id_branch_jump, id_wb_sel, flush, ex_stall,
      input  ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_alu_op, ex_reg_write_en, ex_data1_alu_sel, ex_data2_alu_sel,
             ex_mem_write, ex_mem_read, ex_branch_jump, ex_wb_sel,
             stall_out, bubble_cnt
   );

   modport slave (
      input  id_valid, id_pc, id_data1, id_data2, id_imm, id_rs1, id_rs2, id_rd,
             id_rs1_used, id_rs2_used, id_alu_op, id_reg_write_en,
             id_data1_alu_sel, id_data2_alu_sel, id_mem_write, id_mem_read,
             id_branch_jump, id_wb_sel, flush, ex_stall,
      output ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_alu_op, ex_reg_write_en, ex_data1_alu_sel, ex_data2_alu_sel,
             ex_mem_write, ex_mem_read, ex_branch_jump, ex_wb_sel,
             stall_out, bubble_cnt
   );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use hazard equation; shared with the forwarding logic.
module load_use_detect
   import id_ex_stage_reg_pkg::*;
(
   input  logic                i_ex_valid,
   input  logic [MEM_RD_W-1:0] i_ex_mem_read,
   input  logic [REG_W-1:0]    i_ex_rd,
   input  logic                i_id_valid,
   input  logic [REG_W-1:0]    i_id_rs1,
   input  logic                i_id_rs1_used,
   input  logic [REG_W-1:0]    i_id_rs2,
   input  logic                i_id_rs2_used,
   output logic                o_hazard
);

   logic w_load_in_ex;
   logic w_src_match;

   // x0 is never a real producer, so a load to x0 cannot create a dependency.
   assign w_load_in_ex = i_ex_valid && is_load(i_ex_mem_read) && (i_ex_rd != '0);
   assign w_src_match  = (i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_rs2_used && (i_id_rs2 == i_ex_rd));
   assign o_hazard     = w_load_in_ex && i_id_valid && w_src_match;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// EX-busy hold and a saturating bubble counter.
module id_ex_stage_reg
   import id_ex_stage_reg_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int CNT_WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   id_ex_stage_reg_if.slave  bus
);

   logic                 r_valid;
   ctrl_t                r_ctrl;
   regs_t                r_regs;
   logic [XLEN-1:0]      r_pc;
   logic [XLEN-1:0]      r_data1;
   logic [XLEN-1:0]      r_data2;
   logic [XLEN-1:0]      r_imm;
   logic [CNT_WIDTH-1:0] r_bubble_cnt;

   ctrl_t w_id_ctrl;
   regs_t w_id_regs;
   logic  w_hazard;

   assign w_id_ctrl = '{alu_op:        bus.id_alu_op,
                        reg_write_en:  bus.id_reg_write_en,
                        data1_alu_sel: bus.id_data1_alu_sel,
                        data2_alu_sel: bus.id_data2_alu_sel,
                        mem_write:     bus.id_mem_write,
                        mem_read:      bus.id_mem_read,
                        branch_jump:   bus.id_branch_jump,
                        wb_sel:        bus.id_wb_sel};
   assign w_id_regs = '{rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd};

   load_use_detect u_lud (
      .i_ex_valid    (r_valid),
      .i_ex_mem_read (r_ctrl.mem_read),
      .i_ex_rd       (r_regs.rd),
      .i_id_valid    (bus.id_valid),
      .i_id_rs1      (bus.id_rs1),
      .i_id_rs1_used (bus.id_rs1_used),
      .i_id_rs2      (bus.id_rs2),
      .i_id_rs2_used (bus.id_rs2_used),
      .o_hazard      (w_hazard)
   );

   // A flush kills the ID instruction, so upstream must not be held.
   assign bus.stall_out = (w_hazard || bus.ex_stall) && !bus.flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid      <= 1'b0;
         r_ctrl       <= CTRL_NOP;
         r_regs       <= REGS_NOP;
         r_pc         <= '0;
         r_data1      <= '0;
         r_data2      <= '0;
         r_imm        <= '0;
         r_bubble_cnt <= '0;
      end else if (bus.flush) begin
         r_valid <= 1'b0;
         r_ctrl  <= CTRL_NOP;
         r_regs  <= REGS_NOP;
         r_pc    <= '0;
         r_data1 <= '0;
         r_data2 <= '0;
         r_imm   <= '0;
      end else if (bus.ex_stall) begin
         // Hold everything; any hazard is re-evaluated once EX frees up.
      end else if (w_hazard) begin
         r_valid <= 1'b0;
         r_ctrl  <= CTRL_NOP;
         r_regs  <= REGS_NOP;
         r_pc    <= '0;
         r_data1 <= '0;
         r_data2 <= '0;
         r_imm   <= '0;
         if (r_bubble_cnt != {CNT_WIDTH{1'b1}})
            r_bubble_cnt <= r_bubble_cnt + CNT_WIDTH'(1);
      end else begin
         r_valid <= bus.id_valid;
         r_ctrl  <= w_id_ctrl;
         r_regs  <= w_id_regs;
         r_pc    <= bus.id_pc;
         r_data1 <= bus.id_data1;
         r_data2 <= bus.id_data2;
         r_imm   <= bus.id_imm;
      end
   end

   assign bus.ex_valid         = r_valid;
   assign bus.ex_pc            = r_pc;
   assign bus.ex_data1         = r_data1;
   assign bus.ex_data2         = r_data2;
   assign bus.ex_imm           = r_imm;
   assign bus.ex_rs1           = r_regs.rs1;
   assign bus.ex_rs2           = r_regs.rs2;
   assign bus.ex_rd            = r_regs.rd;
   assign bus.ex_alu_op        = r_ctrl.alu_op;
   assign bus.ex_reg_write_en  = r_ctrl.reg_write_en;
   assign bus.ex_data1_alu_sel = r_ctrl.data1_alu_sel;
   assign bus.ex_data2_alu_sel = r_ctrl.data2_alu_sel;
   assign bus.ex_mem_write     = r_ctrl.mem_write;
   assign bus.ex_mem_read      = r_ctrl.mem_read;
   assign bus.ex_branch_jump   = r_ctrl.branch_jump;
   assign bus.ex_wb_sel        = r_ctrl.wb_sel;
   assign bus.bubble_cnt       = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, capture, load-use bubbles,
// flush/stall priority, reset mid-hazard and counter saturation (CNT_WIDTH=4).
module tb_id_ex_stage_reg;

   localparam int XLEN = 32;
   localparam int CW   = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   id_ex_stage_reg_if #(.XLEN(XLEN), .CNT_WIDTH(CW)) bus ();

   id_ex_stage_reg #(.XLEN(XLEN), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic rwe, input logic [3:0] mr, input logic [1:0] wb);
      bus.id_valid         = v;
      bus.id_pc            = pc;
      bus.id_data1         = d1;
      bus.id_data2         = d2;
      bus.id_imm           = pc + 32'h10;
      bus.id_rs1           = rs1;
      bus.id_rs2           = rs2;
      bus.id_rd            = rd;
      bus.id_rs1_used      = u1;
      bus.id_rs2_used      = u2;
      bus.id_alu_op        = 5'd0;
      bus.id_reg_write_en  = rwe;
      bus.id_data1_alu_sel = 1'b0;
      bus.id_data2_alu_sel = |mr;
      bus.id_mem_write     = 3'd0;
      bus.id_mem_read      = mr;
      bus.id_branch_jump   = 3'd0;
      bus.id_wb_sel        = wb;
      #1;
   endtask

   initial begin
      bus.flush    = 1'b0;
      bus.ex_stall = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);

      // reset held two cycles
      tick; tick;
      chk("rst_valid", bus.ex_valid, 0);
      chk("rst_rd", bus.ex_rd, 0);
      chk("rst_pc", bus.ex_pc, 0);
      chk("rst_cnt", bus.bubble_cnt, 0);
      chk("rst_stall", bus.stall_out, 0);
      reset = 1'b0;

      // ADD x3,x1,x2
      drive(1'b1, 32'h100, 5, 7, 1, 2, 3, 1'b1, 1'b1, 1'b1, 4'd0, 2'd1);
      tick;
      chk("add_rd", bus.ex_rd, 3);
      chk("add_d1", bus.ex_data1, 5);
      chk("add_d2", bus.ex_data2, 7);
      chk("add_valid", bus.ex_valid, 1);
      chk("add_imm", bus.ex_imm, 32'h110);
      chk("add_stall", bus.stall_out, 0);

      // LW x5 then ADD x6,x5,x1 -> one bubble
      drive(1'b1, 32'h104, 0, 0, 2, 0, 5, 1'b1, 1'b0, 1'b1, 4'b1010, 2'd2);
      tick;
      chk("lw_mr", bus.ex_mem_read, 4'b1010);
      drive(1'b1, 32'h108, 11, 12, 5, 1, 6, 1'b1, 1'b1, 1'b1, 4'd0, 2'd1);
      chk("lu_stall", bus.stall_out, 1);
      tick;
      chk("lu_bub_valid", bus.ex_valid, 0);
      chk("lu_bub_mr", bus.ex_mem_read, 0);
      chk("lu_bub_rwe", bus.ex_reg_write_en, 0);
      chk("lu_bub_rd", bus.ex_rd, 0);
      chk("lu_bub_pc", bus.ex_pc, 0);
      chk("lu_cnt1", bus.bubble_cnt, 1);
      chk("lu_stall_clr", bus.stall_out, 0);
      tick;
      chk("lu_cap_rd", bus.ex_rd, 6);
      chk("lu_cap_pc", bus.ex_pc, 32'h108);
      chk("lu_cap_valid", bus.ex_valid, 1);

      // LW x0 never stalls
      drive(1'b1, 32'h120, 0, 0, 1, 0, 0, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd2);
      tick;
      drive(1'b1, 32'h124, 0, 0, 0, 0, 4, 1'b1, 1'b0, 1'b1, 4'd0, 2'd1);
      chk("x0_stall", bus.stall_out, 0);
      tick;
      // rs1 matches but is unused
      drive(1'b1, 32'h13c, 0, 0, 1, 0, 7, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2);
      tick;
      drive(1'b1, 32'h140, 0, 0, 7, 3, 8, 1'b0, 1'b1, 1'b1, 4'd0, 2'd1);
      chk("unused_stall", bus.stall_out, 0);
      chk("unused_cnt", bus.bubble_cnt, 1);
      tick;
      chk("unused_rd", bus.ex_rd, 8);
      chk("unused_pc", bus.ex_pc, 32'h140);

      // hazard + flush together
      drive(1'b1, 32'h180, 0, 0, 1, 0, 7, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2);
      tick;
      drive(1'b1, 32'h184, 0, 0, 7, 0, 11, 1'b1, 1'b0, 1'b1, 4'd0, 2'd1);
      bus.flush = 1'b1;
      #1;
      chk("fl_stall", bus.stall_out, 0);
      tick;
      bus.flush = 1'b0;
      chk("fl_valid", bus.ex_valid, 0);
      chk("fl_pc", bus.ex_pc, 0);
      chk("fl_rd", bus.ex_rd, 0);
      chk("fl_cnt", bus.bubble_cnt, 1);

      // ex_stall held 3 cycles over a pending hazard
      drive(1'b1, 32'h200, 0, 0, 1, 0, 9, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd2);
      chk("pre_st_stall", bus.stall_out, 0);
      tick;
      chk("st_ld_rd", bus.ex_rd, 9);
      chk("st_ld_mr", bus.ex_mem_read, 4'b0010);
      drive(1'b1, 32'h204, 32'h55, 0, 9, 0, 10, 1'b1, 1'b0, 1'b1, 4'd0, 2'd1);
      bus.ex_stall = 1'b1;
      #1;
      chk("st_stall", bus.stall_out, 1);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("st_hold_pc", bus.ex_pc, 32'h200);
         chk("st_hold_rd", bus.ex_rd, 9);
         chk("st_hold_cnt", bus.bubble_cnt, 1);
         chk("st_hold_stall", bus.stall_out, 1);
      end
      bus.ex_stall = 1'b0;
      #1;
      chk("st_rel_stall", bus.stall_out, 1);
      tick;
      chk("st_bub_valid", bus.ex_valid, 0);
      chk("st_bub_cnt", bus.bubble_cnt, 2);
      tick;
      chk("st_cap_pc", bus.ex_pc, 32'h204);
      chk("st_cap_rd", bus.ex_rd, 10);
      chk("st_cap_d1", bus.ex_data1, 32'h55);

      // id_valid=0 passes controls through with ex_valid=0
      drive(1'b0, 32'h220, 0, 0, 0, 0, 12, 1'b0, 1'b0, 1'b1, 4'd0, 2'd1);
      tick;
      chk("inv_valid", bus.ex_valid, 0);
      chk("inv_rd", bus.ex_rd, 12);
      chk("inv_rwe", bus.ex_reg_write_en, 1);

      // reset during a hazard
      drive(1'b1, 32'h300, 0, 0, 1, 0, 5, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd2);
      tick;
      drive(1'b1, 32'h304, 0, 0, 5, 0, 6, 1'b1, 1'b0, 1'b1, 4'd0, 2'd1);
      chk("rh_stall", bus.stall_out, 1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("rh_valid", bus.ex_valid, 0);
      chk("rh_pc", bus.ex_pc, 0);
      chk("rh_cnt", bus.bubble_cnt, 0);
      chk("rh_stall_after", bus.stall_out, 0);

      // 17 load-use hazards saturate the 4-bit counter at 15
      for (int k = 1; k <= 17; k++) begin
         drive(1'b1, 32'h400, 0, 0, 1, 0, 5, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd2);
         tick;
         drive(1'b1, 32'h404, 0, 0, 5, 0, 6, 1'b1, 1'b0, 1'b1, 4'd0, 2'd1);
         tick;
         if (k == 14) chk("sat_cnt14", bus.bubble_cnt, 14);
         if (k == 15) chk("sat_cnt15", bus.bubble_cnt, 15);
      end
      chk("sat_cnt17", bus.bubble_cnt, 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
ID/EX pipeline register for the RV32IM core. It sits directly downstream of the ID-stage control unit and register file, and latches decoded control and operand data for the EX stage. It contains the load-use hazard detector and inserts a bubble when a load-use hazard occurs. It also honours a flush from branch resolution and a hold from a busy EX stage (multi-cycle M-extension), and counts inserted bubbles for performance monitoring.

Parameters:
XLEN, 32, datapath width
CNT_WIDTH, 32, width of the saturating bubble counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of the ID instruction
id_data1, id_data2  in  XLEN  register-file read data
id_imm  in  XLEN  generated immediate
id_rs1, id_rs2, id_rd  in  5  register indices
id_rs1_used, id_rs2_used  in  1  instruction reads rs1 / rs2
id_alu_op  in  5  ALU operation
id_reg_write_en, id_data1_alu_sel, id_data2_alu_sel  in  1  control bits
id_mem_write  in  3  store type; nonzero = store
id_mem_read  in  4  load type; nonzero = load
id_branch_jump  in  3  branch/jump type; nonzero = control transfer
id_wb_sel  in  2  writeback source select
flush  in  1  branch/jump taken in EX; kill the ID instruction
ex_stall  in  1  EX busy; hold this register
ex_*  out  (same widths as id_* above, excluding rs*_used)  registered copies
ex_valid  out  1  EX instruction valid
stall_out  out  1  combinational; hold PC and IF/ID
bubble_cnt  out  CNT_WIDTH  number of load-use bubbles inserted

Behaviour:
- Reset:
  - Single clock; reset is synchronous and active-high, named clk / reset.
  - On reset, every ex_* output, ex_valid and bubble_cnt become 0.
- Hazard (combinational), asserted when all of the following hold:
  - ex_valid and ex_mem_read != 0 and ex_rd != 0 and id_valid;
  - and either (id_rs1_used and id_rs1 == ex_rd) or (id_rs2_used and id_rs2 == ex_rd).
- stall_out = (hazard or ex_stall) and not flush.
- Register update priority, per rising edge:
  1. reset: clear everything.
  2. flush: load a bubble (all ex_* = 0, ex_valid = 0); bubble_cnt unchanged.
  3. ex_stall: hold all ex_* and ex_valid; bubble_cnt unchanged. A hazard in this cycle is ignored; it is re-evaluated next cycle.
  4. hazard: load a bubble; bubble_cnt increments and saturates at all-ones.
  5. otherwise: capture all id_* inputs; ex_valid = id_valid.
- Latency is 1 cycle ID to EX. A load-use hazard costs exactly 1 bubble, because the hazard clears once the load leaves EX.
- A bubble is all-zero, so no register write, no memory access and no branch can occur.
- id_valid = 0 with no other event: the register captures the inputs with ex_valid = 0, and control outputs pass through as given. Downstream logic must gate on ex_valid.
- Reset asserted mid-stall or mid-hazard: reset wins; stall_out follows the post-reset state on the next cycle.

Decomposition:
- Shared encodings header holds the control-field width constants (ALU_OP_W = 5, MEM_RD_W = 4, MEM_WR_W = 3, BJ_W = 3, WB_W = 2) and the bubble/NOP constant bundle.
- Sub-module load_use_detect is purely combinational: the hazard equation only. It is reused by the forwarding logic.

Test Plan:
1. Reset held 2 cycles → all ex_* = 0, ex_valid = 0, bubble_cnt = 0, stall_out = 0.
2. ADD x3,x1,x2 (id_alu_op = 0, reg_write_en = 1, id_rd = 3, id_data1 = 5, id_data2 = 7, id_valid = 1) → next edge: ex_rd = 3, ex_data1 = 5, ex_data2 = 7, ex_valid = 1.
3. LW x5 in EX (mem_read = 4'b1010), ID holds ADD x6,x5,x1 with rs1_used → stall_out = 1 that cycle. Next edge: ex_valid = 0, all controls 0, bubble_cnt = 1. Following edge: ADD captured, stall_out = 0.
4. LW x0 in EX, ID reads x0 → stall_out = 0, no bubble. Same hazard pattern with rs1_used = 0 → no stall.
5. Hazard and flush asserted together → stall_out = 0, bubble loaded, bubble_cnt unchanged. Then ex_stall held 3 cycles → ex_* hold their values, stall_out = 1; on release the ID instruction is captured.
6. CNT_WIDTH = 4, 17 consecutive hazards → bubble_cnt saturates at 15.
